// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: FSM encoding and
// the IMEM window that bounds a legal image.
package uart_imem_loader_pkg;

    localparam logic [31:0] IMEM_START = 32'h0000_0000;
    localparam logic [31:0] IMEM_END   = 32'h0000_5000;
    localparam logic [31:0] IMEM_BYTES = IMEM_END - IMEM_START;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; word_valid/word are
// presented in the same cycle as the byte that completes the word.
module loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [23:0] lanes;

    // The completing byte is merged combinationally so the consumer can
    // register the full word on the same edge that accepts that byte.
    assign word_valid = byte_valid && (lane == 2'd3);
    assign word       = {byte_data, lanes};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane  <= 2'd0;
            lanes <= 24'd0;
        end else if (clear) begin
            lane  <= 2'd0;
            lanes <= 24'd0;
        end else if (byte_valid) begin
            lane  <= lane + 2'd1;
            lanes <= {byte_data, lanes[23:8]};
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a length-prefixed image over UART, writes it into IMEM
// through BRAM port B, and holds the CPU in reset until the image is complete.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = IMEM_START,
    parameter logic [31:0] MAX_BYTES   = IMEM_BYTES,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        restart,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum
);

    localparam int IDX_W = $clog2(MAX_BYTES / 4) + 1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    state_t            state, state_next;
    logic [1:0]        hdr_cnt, hdr_cnt_next;
    logic [23:0]       hdr_buf;
    logic [31:0]       len_full;
    logic [IDX_W-1:0]  word_idx, last_idx;
    logic              last_pending;
    logic [31:0]       tmo_cnt;
    logic              tmo_active, tmo_hit, hdr_last, len_bad, rearm;
    logic              pk_valid, pk_clear, pk_word_valid;
    logic [31:0]       pk_word;

    assign len_full   = {rx_data, hdr_buf};
    assign hdr_last   = (state == S_HDR) && rx_valid && (hdr_cnt == 2'd3);
    assign len_bad    = (len_full[1:0] != 2'b00) || (len_full > MAX_BYTES);
    assign tmo_active = (state == S_DATA) || ((state == S_HDR) && (hdr_cnt != 2'd0));
    assign tmo_hit    = tmo_active && (tmo_cnt >= TIMEOUT_CYC);
    assign rearm      = restart && ((state == S_DONE) || (state == S_ERR));

    // Bytes after the final word are not fed in; the packer is held empty
    // whenever the payload phase is not active.
    assign pk_valid = (state == S_DATA) && rx_valid && !last_pending;
    assign pk_clear = (state != S_DATA);

    loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (rx_data),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        hdr_cnt_next = hdr_cnt;
        unique case (state)
            S_HDR: begin
                if (rx_valid) begin
                    hdr_cnt_next = hdr_cnt + 2'd1;
                    if (hdr_last) begin
                        if (len_full == 32'd0) state_next = S_DONE;
                        else if (len_bad)      state_next = S_ERR;
                        else                   state_next = S_DATA;
                    end
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_DATA: begin
                if (last_pending)  state_next = S_DONE;
                else if (tmo_hit)  state_next = S_ERR;
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_next   = S_HDR;
                    hdr_cnt_next = 2'd0;
                end
            end
            default: state_next = S_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_HDR;
            hdr_cnt      <= 2'd0;
            hdr_buf      <= 24'd0;
            word_idx     <= '0;
            last_idx     <= '0;
            last_pending <= 1'b0;
            tmo_cnt      <= 32'd0;
            mem_we       <= 4'h0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= 32'd0;
            checksum     <= 32'd0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_next;
            hdr_cnt      <= hdr_cnt_next;
            mem_we       <= 4'h0;
            last_pending <= 1'b0;

            if (rx_valid || !tmo_active) tmo_cnt <= 32'd0;
            else                         tmo_cnt <= tmo_cnt + 32'd1;

            if ((state == S_HDR) && rx_valid) begin
                hdr_buf <= {rx_data, hdr_buf[23:8]};
                if (hdr_cnt == 2'd3) begin
                    last_idx <= len_full[IDX_W+1:2] - IDX_ONE;
                    word_idx <= '0;
                end
            end

            if (pk_word_valid) begin
                mem_we       <= 4'hF;
                mem_addr     <= BASE_ADDR + (32'(word_idx) << 2);
                mem_wdata    <= pk_word;
                checksum     <= checksum + pk_word;
                word_idx     <= word_idx + IDX_ONE;
                last_pending <= (word_idx == last_idx);
            end

            if (rearm) begin
                hdr_buf  <= 24'd0;
                word_idx <= '0;
                last_idx <= '0;
                tmo_cnt  <= 32'd0;
                mem_addr <= BASE_ADDR;
                checksum <= 32'd0;
            end

            // Status flags track the state being entered, so they change on the
            // same edge as the state register.
            done     <= (state_next == S_DONE);
            err      <= (state_next == S_ERR);
            cpu_hold <= (state_next != S_DONE);
            busy     <= (state_next == S_DATA) ||
                        ((state_next == S_HDR) && (hdr_cnt_next != 2'd0));
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: an image-level model predicts the
// write sequence, final status and checksum for each directed byte stream.
module tb_uart_imem_loader;

    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam logic [31:0] MAXB    = 32'h0000_5000;
    localparam int          TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        restart;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    int total = 0;
    int bad   = 0;
    int n_writes = 0;

    logic [7:0]  img[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_ck_q[$];
    logic        exp_done, exp_err;
    int          exp_nw;

    uart_imem_loader #(
        .BASE_ADDR   (BASE),
        .MAX_BYTES   (MAXB),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Image-level model: from the header and the bytes actually sent, list the
    // full words that must be written, the running checksum and the outcome.
    task automatic build_expect();
        logic [31:0] len, ck, w;
        int avail, nw;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_nw   = 0;
        ck       = 32'd0;
        len = {img[3], img[2], img[1], img[0]};
        if (len == 32'd0) begin
            exp_done = 1'b1;
        end else if ((len % 4) != 0 || len > MAXB) begin
            exp_err = 1'b1;
        end else begin
            avail = img.size() - 4;
            nw = ((avail < int'(len)) ? avail : int'(len)) / 4;
            for (int k = 0; k < nw; k++) begin
                w = {img[4+4*k+3], img[4+4*k+2], img[4+4*k+1], img[4+4*k]};
                ck = ck + w;
                exp_addr_q.push_back(BASE + 32'(4 * k));
                exp_data_q.push_back(w);
                exp_ck_q.push_back(ck);
            end
            exp_nw = nw;
            if (avail >= int'(len)) exp_done = 1'b1;
            else                    exp_err  = 1'b1;
        end
    endtask

    // Single compare process: every write cycle must match the next predicted
    // write, and the CPU may only be released while done is asserted.
    always @(negedge clk) begin
        if (!rst) begin
            check("hold_vs_done", {31'd0, cpu_hold}, {31'd0, !done});
            if (mem_we != 4'h0) begin
                n_writes++;
                check("we_full", {28'd0, mem_we}, 32'h0000_000F);
                check("write_predicted", {31'd0, exp_addr_q.size() != 0}, 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check("wr_addr", mem_addr, exp_addr_q.pop_front());
                    check("wr_data", mem_wdata, exp_data_q.pop_front());
                    check("wr_checksum", checksum, exp_ck_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_img(input int gap, input bit chk_busy);
        for (int i = 0; i < img.size(); i++) begin
            rx_valid = 1'b1;
            rx_data  = img[i];
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            if (i == 0 && chk_busy) check("busy_first_byte", {31'd0, busy}, 32'd1);
            tick(gap - 1);
        end
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while (!(done || err) && k < budget) begin
            tick(1);
            k++;
        end
        check("end_reached", {31'd0, done || err}, 32'd1);
    endtask

    task automatic check_outcome(input int n0);
        check("done", {31'd0, done}, {31'd0, exp_done});
        check("err", {31'd0, err}, {31'd0, exp_err});
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("write_count", 32'(n_writes - n0), 32'(exp_nw));
        check("writes_left", 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("rs_done", {31'd0, done}, 32'd0);
        check("rs_err", {31'd0, err}, 32'd0);
        check("rs_hold", {31'd0, cpu_hold}, 32'd1);
        check("rs_busy", {31'd0, busy}, 32'd0);
        check("rs_checksum", checksum, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, {28'd0, mem_we}, 32'd0);
        check({tag, "_addr"}, mem_addr, BASE);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_checksum"}, checksum, 32'd0);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        tick(3);
        check_reset_values("reset");
        rst = 1'b0;
        tick(2);

        // Two-word image, one byte every 10 cycles.
        img = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
        build_expect();
        n0 = n_writes;
        send_img(10, 1'b1);
        wait_end(10);
        check_outcome(n0);
        check("slow_checksum", checksum, 32'h0010_00A6);
        check("slow_nwrites", 32'(n_writes - n0), 32'd2);
        check("slow_last_addr", mem_addr, 32'h0000_0004);
        check("slow_last_data", mem_wdata, 32'h0010_0093);
        pulse_restart();

        // Same image back to back: the write of word 0 overlaps byte 0 of word 1.
        build_expect();
        n0 = n_writes;
        send_img(1, 1'b1);
        wait_end(5);
        check_outcome(n0);
        check("fast_checksum", checksum, 32'h0010_00A6);
        check("fast_nwrites", 32'(n_writes - n0), 32'd2);
        pulse_restart();

        // Length not a multiple of four.
        img = '{8'h06, 8'h00, 8'h00, 8'h00};
        build_expect();
        n0 = n_writes;
        send_img(3, 1'b1);
        wait_end(5);
        check_outcome(n0);
        check("misalign_err", {31'd0, err}, 32'd1);
        pulse_restart();

        // Length one word beyond the IMEM region.
        img = '{8'h04, 8'h50, 8'h00, 8'h00};
        build_expect();
        n0 = n_writes;
        send_img(2, 1'b1);
        wait_end(5);
        check_outcome(n0);
        check("toolong_err", {31'd0, err}, 32'd1);
        pulse_restart();

        // Stream stalls after five payload bytes: one write, then timeout.
        img = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
        build_expect();
        n0 = n_writes;
        send_img(2, 1'b1);
        tick(TIMEOUT - 10);
        check("no_early_timeout", {31'd0, err}, 32'd0);
        check("busy_while_waiting", {31'd0, busy}, 32'd1);
        wait_end(40);
        check_outcome(n0);
        check("timeout_nwrites", 32'(n_writes - n0), 32'd1);
        pulse_restart();

        // Asynchronous reset between payload bytes.
        build_expect();
        send_img(2, 1'b1);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        check("ck_before_rst", checksum, 32'h0000_0013);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        tick(2);
        rst = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_ck_q.delete();
        tick(1);

        // Zero-length image completes immediately and ignores later bytes.
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        build_expect();
        n0 = n_writes;
        send_img(1, 1'b1);
        wait_end(2);
        check_outcome(n0);
        img = '{8'h13, 8'h00, 8'h00, 8'h00};
        send_img(1, 1'b0);
        tick(2);
        check("zero_still_done", {31'd0, done}, 32'd1);
        check("zero_checksum", checksum, 32'd0);
        check("zero_nwrites", 32'(n_writes - n0), 32'd0);
        pulse_restart();

        // Three-word image with a mid-range gap.
        img = '{8'h0C, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        build_expect();
        n0 = n_writes;
        send_img(3, 1'b1);
        wait_end(10);
        check_outcome(n0);
        check("three_checksum", checksum, 32'h9966_32FF);
        check("three_last_addr", mem_addr, 32'h0000_0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
